sdram_rr_scheduler: RTL

Front-end scheduler that shares one single-command SDRAM core among four requesters.
- Round-robin arbitration across the four channels.
- Latches each channel's command, issues it to the core with a valid/ready handshake, and routes read data back.
- Owns the periodic auto-refresh timer and gives refresh priority over all channels.
- Sits between the video/CPU/sound clients and the SDRAM command core; exactly one transaction is outstanding at a time.

---
 rtl/sdram_sched_pkg.sv | 39 +++
 rtl/sdram_refresh_timer.sv | 46 ++++
 rtl/sdram_rr_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types, sizes and the round-robin pick helper for the SDRAM front-end scheduler.
package sdram_sched_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_REFRESH = 2'd3
   } state_t;

   typedef struct packed {
      logic            found;
      logic [CH_W-1:0] idx;
   } pick_t;

   // Scanning from the highest offset down leaves the channel closest to ptr as the winner.
   function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req, input logic [CH_W-1:0] ptr);
      pick_t           res;
      logic [CH_W-1:0] cand;
      res.found = 1'b0;
      res.idx   = {CH_W{1'b0}};
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         cand = ptr + CH_W'(k);
         if (req[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval timer with a single-deep pending flag and sticky overrun.
module sdram_refresh_timer #(
   parameter int REFRESH_INTERVAL = 750
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ref_clr,
   output logic ref_due,
   output logic ref_overrun
);

   localparam int CNT_W = $clog2(REFRESH_INTERVAL);

   logic [CNT_W-1:0] cnt_r;
   logic             pending_r;
   logic             overrun_r;
   logic             wrap_s;

   assign wrap_s      = (cnt_r == CNT_W'(REFRESH_INTERVAL - 1));
   // The wrap cycle already counts as due so a refresh wins against a request arriving with it.
   assign ref_due     = pending_r | wrap_s;
   assign ref_overrun = overrun_r;

   // Interval counter, pending refresh and overrun flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r     <= {CNT_W{1'b0}};
         pending_r <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            pending_r <= 1'b1;
            if (pending_r) begin
               overrun_r <= 1'b1;
            end
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (ref_clr) begin
               pending_r <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/sdram_rr_scheduler.sv
// Four-channel round-robin front end for a single-command SDRAM core, with refresh priority
// and a read-data timeout; one transaction is outstanding at a time.
module sdram_rr_scheduler
   import sdram_sched_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 750,
   parameter int RD_TIMEOUT       = 63
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_we,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   output logic [NUM_CH-1:0]        ch_gnt,
   output logic [NUM_CH-1:0]        ch_done,
   output logic [DATA_W-1:0]        ch_rdata,
   input  logic                     core_init_done,
   output logic                     core_cmd_valid,
   input  logic                     core_cmd_ready,
   output logic                     core_cmd_we,
   output logic [ADDR_W-1:0]        core_cmd_addr,
   output logic [DATA_W-1:0]        core_cmd_wdata,
   input  logic                     core_rvalid,
   input  logic [DATA_W-1:0]        core_rdata,
   output logic                     core_ref_valid,
   input  logic                     core_ref_ready,
   output logic                     ref_overrun,
   output logic                     rd_timeout
);

   localparam int TO_W = $clog2(RD_TIMEOUT + 1);

   state_t            state_r;
   logic [CH_W-1:0]   rr_ptr_r;
   logic [CH_W-1:0]   cur_ch_r;
   logic [TO_W-1:0]   to_cnt_r;
   logic              ref_due_s;
   logic              ref_clr_s;
   pick_t             pick_s;
   logic [NUM_CH-1:0] cur_onehot_s;

   assign pick_s       = rr_pick(ch_req, rr_ptr_r);
   assign ref_clr_s    = core_ref_valid & core_ref_ready;
   assign cur_onehot_s = NUM_CH'(1) << cur_ch_r;

   sdram_refresh_timer #(
      .REFRESH_INTERVAL(REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .ref_clr    (ref_clr_s),
      .ref_due    (ref_due_s),
      .ref_overrun(ref_overrun)
   );

   // Scheduler FSM with registered grant/done pulses and core command fields.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         rr_ptr_r       <= {CH_W{1'b0}};
         cur_ch_r       <= {CH_W{1'b0}};
         to_cnt_r       <= {TO_W{1'b0}};
         ch_gnt         <= {NUM_CH{1'b0}};
         ch_done        <= {NUM_CH{1'b0}};
         ch_rdata       <= {DATA_W{1'b0}};
         core_cmd_valid <= 1'b0;
         core_cmd_we    <= 1'b0;
         core_cmd_addr  <= {ADDR_W{1'b0}};
         core_cmd_wdata <= {DATA_W{1'b0}};
         core_ref_valid <= 1'b0;
         rd_timeout     <= 1'b0;
      end else begin
         ch_gnt  <= {NUM_CH{1'b0}};
         ch_done <= {NUM_CH{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (!core_init_done) begin
                  state_r <= ST_IDLE;
               end else if (ref_due_s) begin
                  core_ref_valid <= 1'b1;
                  state_r        <= ST_REFRESH;
               end else if (pick_s.found) begin
                  core_cmd_we    <= ch_we[pick_s.idx];
                  core_cmd_addr  <= ch_addr[pick_s.idx*ADDR_W +: ADDR_W];
                  core_cmd_wdata <= ch_wdata[pick_s.idx*DATA_W +: DATA_W];
                  core_cmd_valid <= 1'b1;
                  ch_gnt         <= NUM_CH'(1) << pick_s.idx;
                  cur_ch_r       <= pick_s.idx;
                  rr_ptr_r       <= pick_s.idx + CH_W'(1);
                  state_r        <= ST_ISSUE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (core_cmd_ready) begin
                  core_cmd_valid <= 1'b0;
                  to_cnt_r       <= {TO_W{1'b0}};
                  if (core_cmd_we) begin
                     ch_done <= cur_onehot_s;
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_WAIT_RD;
                  end
               end else begin
                  state_r <= ST_ISSUE;
               end
            end
            ST_WAIT_RD: begin
               if (core_rvalid) begin
                  ch_rdata <= core_rdata;
                  ch_done  <= cur_onehot_s;
                  state_r  <= ST_IDLE;
               end else if (to_cnt_r == TO_W'(RD_TIMEOUT - 1)) begin
                  // The requester still gets a done pulse so it never hangs on a dead core.
                  rd_timeout <= 1'b1;
                  ch_rdata   <= TIMEOUT_DATA;
                  ch_done    <= cur_onehot_s;
                  state_r    <= ST_IDLE;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
            end
            ST_REFRESH: begin
               if (core_ref_ready) begin
                  core_ref_valid <= 1'b0;
                  state_r        <= ST_IDLE;
               end else begin
                  state_r <= ST_REFRESH;
               end
            end
            default: begin
               core_cmd_valid <= 1'b0;
               core_ref_valid <= 1'b0;
               state_r        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
